pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter FILL_CYCLES, default 3, meaning the number of post-reset cycles spent draining the pipeline.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, meaning the number of consecutive memory-wait cycles before MemTimeout is raised.
REQ-003 SHALL have ports clk in 1 (single clock, rising edge); reset_n in 1 (asynchronous, active-low).
REQ-004 SHALL have ports RA1D, RA2D in 4 (Decode source regs); RA1E, RA2E in 4 (Execute source regs); WA3E, WA3M, WA3W in 4 (destination reg per stage).
REQ-005 SHALL have ports RegWriteM, RegWriteW, MemtoRegE in 1 (stage control bits).
REQ-006 SHALL have ports PCWrPendingF in 1 (PCSrcD|PCSrcE|PCSrcM); PCSrcW in 1; BranchTakenE in 1.
REQ-007 SHALL have ports MemReqM in 1 (M stage accesses data memory); MemReadyM in 1 (data memory completes this cycle).
REQ-008 SHALL have port ClrStats in 1 (synchronous clear of statistics).
REQ-009 SHALL have ports ForwardAE, ForwardBE out 2 (operand forwarding select).
REQ-010 SHALL have ports StallF, StallD, StallE, StallM out 1; FlushD, FlushE out 1; KillW out 1 (suppress W-stage register write).
REQ-011 SHALL have ports StallCount out 16 (saturating stall-cycle count); MemTimeout out 1 (sticky error); Busy out 1 (state != RUN).

Function
REQ-012 SHALL implement states FILL, RUN, MEM_WAIT with a cycle counter cnt of 8 bits.
REQ-013 SHALL, in FILL, drive StallF=1, FlushD=1, FlushE=1, KillW=1, and all other stalls 0, with ForwardAE=ForwardBE=00.
REQ-014 SHALL leave FILL for RUN after exactly FILL_CYCLES rising edges following reset_n deassertion.
REQ-015 SHALL compute forwarding combinationally as ForwardAE=10 if RegWriteM && WA3M==RA1E, else 01 if RegWriteW && WA3W==RA1E, else 00; ForwardBE is identical using RA2E; M SHALL have priority over W.
REQ-016 SHALL define ldr_stall = MemtoRegE && (WA3E==RA1D || WA3E==RA2D).
REQ-017 SHALL define mem_wait = MemReqM && !MemReadyM.
REQ-018 SHALL, in RUN with mem_wait=0, drive StallF=ldr_stall|PCWrPendingF, StallD=ldr_stall, FlushD=PCWrPendingF|PCSrcW|BranchTakenE, FlushE=ldr_stall|BranchTakenE, StallE=StallM=0, KillW=0.
REQ-019 SHALL, whenever mem_wait=1 in RUN or MEM_WAIT, drive StallF=StallD=StallE=StallM=1, FlushD=FlushE=0, and KillW=1, so that memory wait overrides all flushes and held branches re-evaluate afterwards.
REQ-020 SHALL transition RUN->MEM_WAIT on mem_wait=1 with cnt cleared, and MEM_WAIT->RUN in the cycle MemReadyM=1; that cycle SHALL use the RUN equations (Mealy, zero added latency).
REQ-021 SHALL increment cnt each MEM_WAIT cycle, saturating at 255, and set MemTimeout when cnt reaches MEM_TIMEOUT; MemTimeout SHALL stay set until reset or ClrStats.
REQ-022 SHALL, when ldr_stall and BranchTakenE coincide, assert FlushE=1 and StallD=1, and StallF SHALL follow REQ-018.
REQ-023 SHALL increment StallCount on each rising edge with StallF=1 while not in FILL, saturating at 0xFFFF; ClrStats SHALL zero StallCount and MemTimeout on the next edge and take priority over increment.
REQ-024 SHALL drive Busy=1 in FILL and MEM_WAIT, and 0 in RUN.

Reset
REQ-025 SHALL, while reset_n=0, immediately set state=FILL, cnt=0, StallCount=0, MemTimeout=0, with outputs per REQ-013 and Busy=1.
REQ-026 SHALL, on reset_n asserted mid-MEM_WAIT, abandon the wait without completing it and restart the FILL sequence after release.

Verification
REQ-027 SHALL be verified by: release reset -> 3 cycles StallF=FlushD=FlushE=KillW=1, Busy=1, then RUN with Busy=0 and StallCount=0.
REQ-028 SHALL be verified by: RegWriteM=1, WA3M=5, RegWriteW=1, WA3W=5, RA1E=5, RA2E=5 -> ForwardAE=ForwardBE=10; with RegWriteM=0 -> 01.
REQ-029 SHALL be verified by: MemtoRegE=1, WA3E=3, RA2D=3 -> StallF=StallD=FlushE=1 for one cycle, and StallCount increments by 1.
REQ-030 SHALL be verified by: MemReqM=1, MemReadyM=0 for 4 cycles, then 1 -> all four stalls=1 and FlushD=0 despite BranchTakenE=1 during the wait; FlushD=1 in the ready cycle; Busy=1 for 4 cycles.
REQ-031 SHALL be verified by: MemReadyM held 0 for 256 cycles -> MemTimeout=1 from cycle 255 and held; ClrStats=1 -> MemTimeout=0 and StallCount=0.
REQ-032 SHALL be verified by: StallF forced high for 70000 cycles -> StallCount=0xFFFF with no wrap.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: post-reset fill sequence,
// operand forwarding, load-use stalls, memory-wait freeze and stall statistics.
module pipeline_ctrl #(
  parameter int FILL_CYCLES = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  RA1E,
  input  logic [3:0]  RA2E,
  input  logic [3:0]  WA3E,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  WA3W,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        PCWrPendingF,
  input  logic        PCSrcW,
  input  logic        BranchTakenE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  input  logic        ClrStats,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        KillW,
  output logic [15:0] StallCount,
  output logic        MemTimeout,
  output logic        Busy
);

  typedef enum logic [1:0] {FILL, RUN, MEM_WAIT} state_t;

  localparam logic [7:0] FILL_LAST   = 8'(FILL_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       timeout_set;
  logic       ldr_stall;
  logic       mem_wait;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The M stage holds the younger result, so it wins over W.
  function automatic logic [1:0] fwd_sel(input logic rw_m, input logic [3:0] wa_m,
                                         input logic rw_w, input logic [3:0] wa_w,
                                         input logic [3:0] ra);
    if (rw_m && (wa_m == ra))      return 2'b10;
    else if (rw_w && (wa_w == ra)) return 2'b01;
    else                           return 2'b00;
  endfunction

  assign ldr_stall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign mem_wait  = MemReqM && !MemReadyM;
  assign Busy      = (state != RUN);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_set = 1'b0;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    KillW       = 1'b0;

    case (state)
      FILL: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        KillW  = 1'b1;
        if (cnt == FILL_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RUN, MEM_WAIT: begin
        ForwardAE = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
        ForwardBE = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);
        // A pending memory access freezes everything; held branches re-flush once it completes.
        if (mem_wait) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          KillW  = 1'b1;
        end else begin
          StallF = ldr_stall | PCWrPendingF;
          StallD = ldr_stall;
          FlushD = PCWrPendingF | PCSrcW | BranchTakenE;
          FlushE = ldr_stall | BranchTakenE;
        end
        if (state == RUN) begin
          if (mem_wait) begin
            state_nxt = MEM_WAIT;
            cnt_nxt   = '0;
          end
        end else if (mem_wait) begin
          cnt_nxt     = sat_inc8(cnt);
          timeout_set = ({1'b0, cnt_nxt} >= TIMEOUT_LIM);
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FILL;
      cnt        <= '0;
      StallCount <= '0;
      MemTimeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ClrStats) begin
        StallCount <= '0;
        MemTimeout <= 1'b0;
      end else begin
        if ((state != FILL) && StallF) StallCount <= sat_inc16(StallCount);
        if (timeout_set) MemTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of the controller.
module tb_pipeline_ctrl;

  localparam int FILL_CYCLES = 3;
  localparam int MEM_TIMEOUT = 255;
  localparam logic [12:0] FILL_VEC = 13'b0000_1000_1111_0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteM, RegWriteW, MemtoRegE;
  logic        PCWrPendingF, PCSrcW, BranchTakenE;
  logic        MemReqM, MemReadyM, ClrStats;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, KillW;
  logic [15:0] StallCount;
  logic        MemTimeout, Busy;
  logic [12:0] obs_ctl;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  int          m_fill;
  bit          m_busy;
  int          m_run;
  int          m_sc;
  bit          m_to;
  logic [12:0] exp_ctl;
  logic [15:0] exp_sc;
  bit          exp_sf;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FILL_CYCLES(FILL_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ClrStats(ClrStats),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .KillW(KillW),
    .StallCount(StallCount), .MemTimeout(MemTimeout), .Busy(Busy)
  );

  assign obs_ctl = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                    FlushD, FlushE, KillW, Busy, MemTimeout};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCWrPendingF = 0; PCSrcW = 0; BranchTakenE = 0;
    MemReqM = 0; MemReadyM = 0; ClrStats = 0;
  endtask

  task automatic model_reset();
    m_fill = FILL_CYCLES; m_busy = 0; m_run = 0; m_sc = 0; m_to = 0;
  endtask

  // Expected outputs for the current cycle from the controller's rules.
  task automatic model_eval();
    logic mw, ldr, sf, sd, se, sm, fd, fe, kw, bz;
    logic [1:0] fa, fb;
    mw = MemReqM && !MemReadyM;
    ldr = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    fa = 0; fb = 0; sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; kw = 0; bz = 1;
    if (m_fill > 0) begin
      sf = 1; fd = 1; fe = 1; kw = 1;
    end else begin
      bz = m_busy;
      if (RegWriteM && WA3M == RA1E) fa = 2; else if (RegWriteW && WA3W == RA1E) fa = 1;
      if (RegWriteM && WA3M == RA2E) fb = 2; else if (RegWriteW && WA3W == RA2E) fb = 1;
      if (mw) begin
        sf = 1; sd = 1; se = 1; sm = 1; kw = 1;
      end else begin
        sf = ldr | PCWrPendingF;
        sd = ldr;
        fd = PCWrPendingF | PCSrcW | BranchTakenE;
        fe = ldr | BranchTakenE;
      end
    end
    exp_sf = sf;
    exp_ctl = {fa, fb, sf, sd, se, sm, fd, fe, kw, bz, m_to};
    exp_sc = 16'(m_sc);
  endtask

  task automatic model_edge();
    bit was_fill, mw;
    model_eval();
    was_fill = (m_fill > 0);
    mw = MemReqM && !MemReadyM;
    if (was_fill) begin
      m_fill--; m_busy = 0; m_run = 0;
    end else if (mw) begin
      m_run++; m_busy = 1;
    end else begin
      m_run = 0; m_busy = 0;
    end
    if (ClrStats) begin
      m_sc = 0; m_to = 0;
    end else begin
      if (!was_fill && exp_sf && m_sc < 65535) m_sc++;
      if (!was_fill && mw && m_run >= MEM_TIMEOUT + 1) m_to = 1;
    end
  endtask

  task automatic tick();
    if (reset_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 0;
    model_reset();
    #3;
    model_eval();
    n_cmp++;
    if (obs_ctl !== FILL_VEC || StallCount !== 16'd0) begin
      n_fail++; $display("FAIL reset_hold: got %b/%h expected %b/0000", obs_ctl, StallCount, FILL_VEC);
    end
    tick();
    reset_n = 1;
    for (int c = 0; c < FILL_CYCLES; c++) begin
      #1; model_eval();
      n_cmp++;
      if (obs_ctl !== FILL_VEC || obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL reset_fill c%0d: got %b expected %b", c, obs_ctl, FILL_VEC);
      end
      tick();
    end
    #1;
    n_cmp++;
    if (Busy !== 1'b0 || StallCount !== 16'd0 || StallF !== 1'b0) begin
      n_fail++; $display("FAIL reset_run: got Busy=%b SC=%h StallF=%b expected 0/0000/0", Busy, StallCount, StallF);
    end
  endtask

  task automatic test_forwarding();
    set_idle();
    RegWriteM = 1; WA3M = 5; RegWriteW = 1; WA3W = 5; RA1E = 5; RA2E = 5;
    #1;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b1010) begin
      n_fail++; $display("FAIL fwd_m_prio: got %b expected 1010", {ForwardAE, ForwardBE});
    end
    RegWriteM = 0;
    #1;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b0101) begin
      n_fail++; $display("FAIL fwd_w: got %b expected 0101", {ForwardAE, ForwardBE});
    end
    RegWriteM = 1; RA2E = 6;
    #1;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b1000) begin
      n_fail++; $display("FAIL fwd_split: got %b expected 1000", {ForwardAE, ForwardBE});
    end
    for (int i = 0; i < 40; i++) begin
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      WA3M = 4'($urandom_range(0, 3)); WA3W = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      #1; model_eval();
      n_cmp++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL fwd_rand i%0d: got %b expected %b", i, obs_ctl, exp_ctl);
      end
    end
    set_idle();
    tick();
  endtask

  task automatic test_ldr_stall();
    logic [15:0] sc0;
    set_idle(); #1;
    sc0 = StallCount;
    MemtoRegE = 1; WA3E = 3; RA2D = 3; RA1D = 7;
    #1;
    n_cmp++;
    if ({StallF, StallD, FlushE, StallE, StallM, KillW} !== 6'b111000) begin
      n_fail++; $display("FAIL ldr_stall: got %b expected 111000", {StallF, StallD, FlushE, StallE, StallM, KillW});
    end
    tick();
    set_idle(); #1;
    n_cmp++;
    if (StallCount !== sc0 + 16'd1 || StallF !== 1'b0) begin
      n_fail++; $display("FAIL ldr_count: got SC=%h StallF=%b expected %h/0", StallCount, StallF, sc0 + 16'd1);
    end
    MemtoRegE = 1; WA3E = 3; RA1D = 3; BranchTakenE = 1;
    #1;
    n_cmp++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1111) begin
      n_fail++; $display("FAIL ldr_branch: got %b expected 1111", {StallF, StallD, FlushD, FlushE});
    end
    tick();
    set_idle();
  endtask

  task automatic test_mem_wait();
    int busy_cnt;
    busy_cnt = 0;
    set_idle();
    for (int c = 0; c < 4; c++) begin
      MemReqM = 1; MemReadyM = 0; BranchTakenE = 1; PCSrcW = 1;
      #1; model_eval();
      n_cmp++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE, KillW} !== 7'b1111001
          || Busy !== (c != 0) || obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL mem_wait c%0d: got %b expected %b", c, obs_ctl, exp_ctl);
      end
      busy_cnt += int'(Busy);
      tick();
    end
    MemReadyM = 1;
    #1; model_eval();
    n_cmp++;
    if (FlushD !== 1'b1 || Busy !== 1'b1 || StallE !== 1'b0 || KillW !== 1'b0 || obs_ctl !== exp_ctl) begin
      n_fail++; $display("FAIL mem_ready: got %b expected %b", obs_ctl, exp_ctl);
    end
    busy_cnt += int'(Busy);
    tick();
    set_idle(); #1;
    n_cmp++;
    if (Busy !== 1'b0 || busy_cnt != 4) begin
      n_fail++; $display("FAIL mem_busy: got Busy=%b busy_cycles=%0d expected 0/4", Busy, busy_cnt);
    end
  endtask

  task automatic test_mid_wait_reset();
    set_idle();
    for (int c = 0; c < 3; c++) begin
      MemReqM = 1; MemReadyM = 0;
      tick();
    end
    #2;
    reset_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (obs_ctl !== FILL_VEC || StallCount !== 16'd0) begin
      n_fail++; $display("FAIL midwait_reset: got %b/%h expected %b/0000", obs_ctl, StallCount, FILL_VEC);
    end
    tick();
    reset_n = 1;
    for (int c = 0; c < FILL_CYCLES; c++) begin
      #1; model_eval();
      n_cmp++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL midwait_fill c%0d: got %b expected %b", c, obs_ctl, exp_ctl);
      end
      tick();
    end
    set_idle(); #1;
    n_cmp++;
    if (Busy !== 1'b0 || StallF !== 1'b0) begin
      n_fail++; $display("FAIL midwait_run: got Busy=%b StallF=%b expected 0/0", Busy, StallF);
    end
  endtask

  task automatic test_timeout();
    set_idle(); ClrStats = 1; tick(); ClrStats = 0;
    for (int k = 1; k <= 260; k++) begin
      MemReqM = 1; MemReadyM = 0;
      #1; model_eval();
      n_cmp++;
      if (obs_ctl !== exp_ctl || StallCount !== exp_sc) begin
        n_fail++; $display("FAIL timeout_k%0d: got %b/%h expected %b/%h", k, obs_ctl, StallCount, exp_ctl, exp_sc);
      end
      if (k == 200 || k == 260) begin
        n_cmp++;
        if (MemTimeout !== (k == 260)) begin
          n_fail++; $display("FAIL timeout_flag k%0d: got %b expected %b", k, MemTimeout, k == 260);
        end
      end
      tick();
    end
    MemReadyM = 1; tick();
    set_idle(); #1;
    n_cmp++;
    if (MemTimeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b expected 1", MemTimeout);
    end
    ClrStats = 1; tick(); ClrStats = 0; #1;
    n_cmp++;
    if (MemTimeout !== 1'b0 || StallCount !== 16'd0) begin
      n_fail++; $display("FAIL timeout_clear: got %b/%h expected 0/0000", MemTimeout, StallCount);
    end
  endtask

  task automatic test_stall_saturation();
    set_idle(); ClrStats = 1; tick(); ClrStats = 0;
    PCWrPendingF = 1;
    for (int i = 0; i < 70000; i++) tick();
    #1; model_eval();
    n_cmp++;
    if (StallCount !== 16'hFFFF || StallCount !== exp_sc) begin
      n_fail++; $display("FAIL stall_sat: got %h expected FFFF", StallCount);
    end
    PCWrPendingF = 0; ClrStats = 1; tick(); ClrStats = 0; #1;
    n_cmp++;
    if (StallCount !== 16'd0) begin
      n_fail++; $display("FAIL stall_clear: got %h expected 0000", StallCount);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom); MemtoRegE = 1'($urandom);
      PCWrPendingF = ($urandom % 4 == 0); PCSrcW = ($urandom % 6 == 0);
      BranchTakenE = ($urandom % 5 == 0);
      MemReqM = ($urandom % 3 == 0); MemReadyM = ($urandom % 4 != 0);
      ClrStats = ($urandom % 60 == 0);
      #1; model_eval();
      n_cmp++;
      if (obs_ctl !== exp_ctl || StallCount !== exp_sc) begin
        n_fail++; $display("FAIL random i%0d: got %b/%h expected %b/%h", i, obs_ctl, StallCount, exp_ctl, exp_sc);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    reset_n = 0;
    model_reset();
    test_reset();
    test_forwarding();
    test_ldr_stall();
    test_mem_wait();
    test_mid_wait_reset();
    test_timeout();
    test_stall_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
